grf_read_port: RTL and testbench
================================

# grf_read_port

Decode-side consumer of the writeback path: holds the 32×32 general register file, serves the two D-stage source reads (rs, rt) with same-cycle write bypass, and commits the writeback stream (address, data, enable). It also keeps a load-use scoreboard of registers with an in-flight load result, and stalls decode while a source register is still pending. It sits between the writeback mux, which supplies WriteAddr/RegData, and the decode/ALU operand path.

## Interface
Parameters:
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired to zero.
- DATA_W, 32, register width.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- RsAddr  input  ADDR_W  first source register, D stage.
- RtAddr  input  ADDR_W  second source register, D stage.
- RsData  output  DATA_W  rs operand (combinational, bypassed).
- RtData  output  DATA_W  rt operand (combinational, bypassed).
- WriteEn  input  1  writeback commit strobe.
- WriteAddr  input  ADDR_W  writeback destination.
- RegData  input  DATA_W  writeback value.
- issue_valid  input  1  a D-stage instruction leaves decode this cycle.
- issue_is_load  input  1  the issuing instruction writes a memory result.
- issue_dest  input  ADDR_W  destination of the issuing instruction.
- flush  input  1  squash all in-flight loads (exception/redirect).
- stall  output  1  a source register of the current D-stage instruction is pending.
- pending_cnt  output  ADDR_W+1  number of registers currently marked busy.

## Operation
- Write: on a rising edge with WriteEn=1 and WriteAddr≠0, regs[WriteAddr] ← RegData. Writes to register 0 are discarded.
- Read:
  - RsData = 0 if RsAddr=0.
  - Otherwise RsData = RegData if WriteEn and WriteAddr=RsAddr (write-first bypass).
  - Otherwise RsData = regs[RsAddr].
  - RtData follows the same rule with RtAddr.
- Scoreboard busy[REG_COUNT-1:1]:
  - Set: issue_valid & issue_is_load & ~stall & issue_dest≠0 sets busy[issue_dest].
  - Clear: WriteEn & WriteAddr≠0 clears busy[WriteAddr].
  - If set and clear target the same register in the same cycle, set wins (the new load is younger).
  - flush=1 clears all busy bits and pending_cnt on the next edge. flush takes priority over set and clear.
- stall = (busy[RsAddr] & RsAddr≠0 & ~(WriteEn & WriteAddr=RsAddr)) | (the same term for Rt). A write landing this cycle resolves the hazard through the bypass.
- pending_cnt is a registered counter, updated as follows:
  - +1 when a set hits a clear register.
  - −1 when a clear hits a busy register that is not being re-set.
  - Net 0 for set+clear on the same register.
  - pending_cnt must always equal popcount(busy).

## Timing
- Reset (asynchronous, reset_n=0): all regs=0, busy=0, pending_cnt=0. With these values, RsData/RtData=0 and stall=0 immediately.
- Reset asserted mid-operation discards all state; no write completes on that edge.
- Read latency is 0 cycles (combinational from address). Write latency is 1 edge, but the value is visible through the bypass in the same cycle.
- stall is combinational from RsAddr/RtAddr/busy/WriteEn/WriteAddr; it has no path from issue_*.
- A load issued at edge N makes the destination busy from cycle N+1. The dependent instruction stalls until the cycle in which writeback presents that address.

## Structure
- Shared package: DATA_W, ADDR_W, REG_COUNT constants, and the ZERO_REG=0 constant.
- One sub-module, grf_scoreboard, holding busy[], pending_cnt and the stall equation. The register array and bypass mux stay in the top module.

## Test plan
- Reset, then write 0x1234_5678 to r8; next cycle RsAddr=8 → RsData=0x1234_5678, stall=0.
- Same cycle WriteEn=1, WriteAddr=9, RegData=0xDEAD_BEEF, RtAddr=9 → RtData=0xDEAD_BEEF before the edge (bypass).
- Write 0xFFFF_FFFF to r0, then RsAddr=0 → RsData=0. Issue a load with issue_dest=0 → pending_cnt stays 0.
- Issue load to r5 → busy; next cycle RsAddr=5 → stall=1, pending_cnt=1. Writeback r5 → stall=0 that cycle; after the edge pending_cnt=0.
- Same-cycle writeback r5 clear and new load issue to r5 → busy[5] stays 1, pending_cnt unchanged.
- Three loads pending (pending_cnt=3), then flush=1 → pending_cnt=0, stall=0. Separately, reset_n low mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/grf_read_port_pkg.sv
// Shared sizing constants for the decode-side general register file.
package grf_read_port_pkg;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/grf_scoreboard.sv
// Load-use scoreboard: busy bit per register, registered popcount, decode stall.
module grf_scoreboard
    import grf_read_port_pkg::*;
#(
    parameter int REG_COUNT = grf_read_port_pkg::REG_COUNT,
    parameter int ADDR_W    = grf_read_port_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic              issue_valid,
    input  logic              issue_is_load,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              flush,
    output logic              stall,
    output logic [ADDR_W:0]   pending_cnt
);

    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busyNext;
    logic [ADDR_W:0]      cntNext;
    logic                 setHit;
    logic                 clrHit;
    logic                 incCnt;
    logic                 decCnt;
    logic                 rsHazard;
    logic                 rtHazard;

    // A write landing this cycle resolves the hazard through the read bypass.
    always_comb begin
        rsHazard = busy[RsAddr] && (RsAddr != ZERO_REG) && !(WriteEn && (WriteAddr == RsAddr));
        rtHazard = busy[RtAddr] && (RtAddr != ZERO_REG) && !(WriteEn && (WriteAddr == RtAddr));
        stall    = rsHazard || rtHazard;
    end

    always_comb begin
        setHit   = issue_valid && issue_is_load && !stall && (issue_dest != ZERO_REG);
        clrHit   = WriteEn && (WriteAddr != ZERO_REG);
        busyNext = busy;
        if (clrHit)
            busyNext[WriteAddr] = 1'b0;
        if (setHit)
            busyNext[issue_dest] = 1'b1;
        busyNext[0] = 1'b0;
        // Count tracks the busy transitions so it stays equal to popcount(busy).
        incCnt  = setHit && !busy[issue_dest];
        decCnt  = clrHit && busy[WriteAddr] && !(setHit && (issue_dest == WriteAddr));
        cntNext = pending_cnt + (ADDR_W+1)'(incCnt) - (ADDR_W+1)'(decCnt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else if (flush) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busyNext;
            pending_cnt <= cntNext;
        end
    end

endmodule

// File: rtl/grf_read_port.sv
// 32x32 general register file with two bypassed D-stage read ports and load-use stall.
module grf_read_port
    import grf_read_port_pkg::*;
#(
    parameter int REG_COUNT = grf_read_port_pkg::REG_COUNT,
    parameter int DATA_W    = grf_read_port_pkg::DATA_W,
    parameter int ADDR_W    = grf_read_port_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] RegData,
    input  logic              issue_valid,
    input  logic              issue_is_load,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              flush,
    output logic              stall,
    output logic [ADDR_W:0]   pending_cnt
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else if (WriteEn && (WriteAddr != ZERO_REG)) begin
            regs[WriteAddr] <= RegData;
        end
    end

    // Write-first bypass; register 0 always reads zero regardless of writes.
    always_comb begin
        RsData = regs[RsAddr];
        if (RsAddr == ZERO_REG)
            RsData = '0;
        else if (WriteEn && (WriteAddr == RsAddr))
            RsData = RegData;

        RtData = regs[RtAddr];
        if (RtAddr == ZERO_REG)
            RtData = '0;
        else if (WriteEn && (WriteAddr == RtAddr))
            RtData = RegData;
    end

    grf_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_scoreboard (
        .clk           (clk),
        .reset_n       (reset_n),
        .RsAddr        (RsAddr),
        .RtAddr        (RtAddr),
        .WriteEn       (WriteEn),
        .WriteAddr     (WriteAddr),
        .issue_valid   (issue_valid),
        .issue_is_load (issue_is_load),
        .issue_dest    (issue_dest),
        .flush         (flush),
        .stall         (stall),
        .pending_cnt   (pending_cnt)
    );

endmodule

// File: tb/tb_grf_read_port.sv
// Directed bench for grf_read_port; expectations queued by stimulus, checked by a negedge monitor.
module tb_grf_read_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  RsAddr, RtAddr, WriteAddr, issue_dest;
    logic [31:0] RsData, RtData, RegData;
    logic        WriteEn, issue_valid, issue_is_load, flush, stall;
    logic [5:0]  pending_cnt;

    typedef struct {
        string       name;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stl;
        logic [5:0]  cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    grf_read_port dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .RsAddr        (RsAddr),
        .RtAddr        (RtAddr),
        .RsData        (RsData),
        .RtData        (RtData),
        .WriteEn       (WriteEn),
        .WriteAddr     (WriteAddr),
        .RegData       (RegData),
        .issue_valid   (issue_valid),
        .issue_is_load (issue_is_load),
        .issue_dest    (issue_dest),
        .flush         (flush),
        .stall         (stall),
        .pending_cnt   (pending_cnt)
    );

    // Monitor: DUT outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checks++;
            if (RsData !== e.rs) begin
                errors++;
                $display("FAIL %s RsData: got %h expected %h", e.name, RsData, e.rs);
            end
            checks++;
            if (RtData !== e.rt) begin
                errors++;
                $display("FAIL %s RtData: got %h expected %h", e.name, RtData, e.rt);
            end
            checks++;
            if (stall !== e.stl) begin
                errors++;
                $display("FAIL %s stall: got %b expected %b", e.name, stall, e.stl);
            end
            checks++;
            if (pending_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s pending_cnt: got %0d expected %0d", e.name, pending_cnt, e.cnt);
            end
        end
    end

    task automatic idle();
        WriteEn       = 1'b0;
        WriteAddr     = 5'd0;
        RegData       = 32'h0;
        issue_valid   = 1'b0;
        issue_is_load = 1'b0;
        issue_dest    = 5'd0;
        flush         = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WriteEn   = 1'b1;
        WriteAddr = a;
        RegData   = d;
    endtask

    task automatic ld(input logic [4:0] d);
        issue_valid   = 1'b1;
        issue_is_load = 1'b1;
        issue_dest    = d;
    endtask

    task automatic rd(input logic [4:0] rs, input logic [4:0] rt);
        RsAddr = rs;
        RtAddr = rt;
    endtask

    task automatic expect_out(input string n, input logic [31:0] rs, input logic [31:0] rt,
                              input logic stl, input logic [5:0] cnt);
        exp_t e;
        e.name = n; e.rs = rs; e.rt = rt; e.stl = stl; e.cnt = cnt;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        rd(5'd0, 5'd0);
        @(posedge clk);
        #1;

        rd(5'd3, 5'd4);
        expect_out("reset", 32'h0, 32'h0, 1'b0, 6'd0);
        tick();
        reset_n = 1'b1;

        wr(5'd8, 32'h1234_5678); rd(5'd0, 5'd0);
        expect_out("wr_r8", 32'h0, 32'h0, 1'b0, 6'd0);
        tick();

        rd(5'd8, 5'd9); wr(5'd9, 32'hDEAD_BEEF);
        expect_out("rd_r8_byp_r9", 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 6'd0);
        tick();

        rd(5'd9, 5'd0); wr(5'd0, 32'hFFFF_FFFF);
        expect_out("wr_r0_no_byp", 32'hDEAD_BEEF, 32'h0, 1'b0, 6'd0);
        tick();

        rd(5'd0, 5'd8); ld(5'd0);
        expect_out("r0_zero_ld_r0", 32'h0, 32'h1234_5678, 1'b0, 6'd0);
        tick();

        rd(5'd1, 5'd2); ld(5'd5);
        expect_out("ld_r5", 32'h0, 32'h0, 1'b0, 6'd0);
        tick();

        rd(5'd5, 5'd8);
        expect_out("stall_rs5", 32'h0, 32'h1234_5678, 1'b1, 6'd1);
        tick();

        rd(5'd0, 5'd5);
        expect_out("stall_rt5", 32'h0, 32'h0, 1'b1, 6'd1);
        tick();

        rd(5'd5, 5'd0); wr(5'd5, 32'h0000_0055);
        expect_out("wb_r5_bypass", 32'h0000_0055, 32'h0, 1'b0, 6'd1);
        tick();

        rd(5'd5, 5'd0); ld(5'd5);
        expect_out("r5_cleared_reld", 32'h0000_0055, 32'h0, 1'b0, 6'd0);
        tick();

        rd(5'd0, 5'd0); wr(5'd5, 32'h0000_0066); ld(5'd5);
        expect_out("set_clr_same", 32'h0, 32'h0, 1'b0, 6'd1);
        tick();

        rd(5'd5, 5'd0); ld(5'd6);
        expect_out("r5_still_busy", 32'h0000_0066, 32'h0, 1'b1, 6'd1);
        tick();

        rd(5'd6, 5'd5);
        expect_out("stalled_ld_dropped", 32'h0, 32'h0000_0066, 1'b1, 6'd1);
        tick();

        rd(5'd6, 5'd0); ld(5'd6);
        expect_out("r6_free_ld", 32'h0, 32'h0, 1'b0, 6'd1);
        tick();

        rd(5'd0, 5'd0); ld(5'd7);
        expect_out("ld_r7", 32'h0, 32'h0, 1'b0, 6'd2);
        tick();

        rd(5'd7, 5'd6); flush = 1'b1;
        expect_out("three_pending", 32'h0, 32'h0, 1'b1, 6'd3);
        tick();

        rd(5'd7, 5'd6);
        expect_out("after_flush", 32'h0, 32'h0, 1'b0, 6'd0);
        tick();

        rd(5'd0, 5'd0); ld(5'd10);
        expect_out("ld_r10", 32'h0, 32'h0, 1'b0, 6'd0);
        tick();

        rd(5'd10, 5'd8);
        expect_out("stall_r10", 32'h0, 32'h1234_5678, 1'b1, 6'd1);
        tick();

        reset_n = 1'b0;
        rd(5'd8, 5'd9);
        expect_out("async_reset", 32'h0, 32'h0, 1'b0, 6'd0);
        tick();
        reset_n = 1'b1;

        rd(5'd8, 5'd10); wr(5'd31, 32'h3131_3131);
        expect_out("post_reset", 32'h0, 32'h0, 1'b0, 6'd0);
        tick();

        rd(5'd31, 5'd31);
        expect_out("rd_r31", 32'h3131_3131, 32'h3131_3131, 1'b0, 6'd0);
        tick();

        for (int i = 0; i < 5 && expQ.size() > 0; i++)
            @(posedge clk);
        if (expQ.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
